voice_alloc: RTL and testbench

Voice allocation scheduler sitting between the MIDI event FIFO and the control port of the 32-entry voice RAM. It accepts note-on/note-off events, keeps a shadow table of which voice holds which note, and picks the target voice: retrigger, free slot or steal. It then issues one write command per event to the voice-RAM writer. It also frees voices when the sample engine reports that a released envelope has reached BLANK.

---
 rtl/voice_alloc.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_voice_alloc.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
// Voice allocation scheduler: scans a shadow voice table once per MIDI event,
// picks retrigger / free / steal target and issues one voice-RAM write command.
module voice_alloc #(
    parameter int unsigned NUM_VOICES = 32,
    parameter int unsigned VOICE_W    = 5
) (
    input  logic               clk32,
    input  logic               rst,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic               ev_on,
    input  logic [6:0]         ev_note,
    input  logic [3:0]         ev_channel,
    input  logic [6:0]         ev_velocity,
    input  logic               rel_valid,
    input  logic [VOICE_W-1:0] rel_voice,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [1:0]         wr_kind,
    output logic [VOICE_W-1:0] wr_voice,
    output logic [6:0]         wr_note,
    output logic [3:0]         wr_channel,
    output logic [6:0]         wr_velocity,
    output logic [VOICE_W:0]   active_count,
    output logic [7:0]         steal_count,
    output logic [7:0]         miss_count
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE, S_ISSUE} state_e;
    typedef enum logic [1:0] {K_START = 2'd0, K_RELEASE = 2'd1, K_STEAL = 2'd2} kind_e;

    localparam logic [VOICE_W-1:0] LAST_IDX = VOICE_W'(NUM_VOICES - 1);

    state_e               state_q, state_d;
    logic [VOICE_W-1:0]   idx_q, idx_d;

    logic                 ev_on_q, ev_on_d;
    logic [6:0]           ev_note_q, ev_note_d;
    logic [3:0]           ev_channel_q, ev_channel_d;
    logic [6:0]           ev_velocity_q, ev_velocity_d;

    logic                 match_found_q, match_found_d;
    logic [VOICE_W-1:0]   match_idx_q, match_idx_d;
    logic                 free_found_q, free_found_d;
    logic [VOICE_W-1:0]   free_idx_q, free_idx_d;
    logic                 rel_found_q, rel_found_d;
    logic [VOICE_W-1:0]   rel_idx_q, rel_idx_d;
    logic [7:0]           rel_age_q, rel_age_d;
    logic                 held_found_q, held_found_d;
    logic [VOICE_W-1:0]   held_idx_q, held_idx_d;
    logic [7:0]           held_age_q, held_age_d;

    kind_e                kind_q, kind_d;
    logic [VOICE_W-1:0]   voice_q, voice_d;

    logic [NUM_VOICES-1:0] used_q, used_d;
    logic [NUM_VOICES-1:0] releasing_q, releasing_d;
    logic [6:0]           note_q    [NUM_VOICES];
    logic [6:0]           note_d    [NUM_VOICES];
    logic [3:0]           channel_q [NUM_VOICES];
    logic [3:0]           channel_d [NUM_VOICES];
    logic [7:0]           stamp_q   [NUM_VOICES];
    logic [7:0]           stamp_d   [NUM_VOICES];
    logic [7:0]           seq_q, seq_d;

    logic [VOICE_W:0]     active_count_q, active_count_d;
    logic [7:0]           steal_count_q, steal_count_d;
    logic [7:0]           miss_count_q, miss_count_d;

    logic [7:0]           scan_age;
    logic                 scan_hit;

    assign ev_ready     = (state_q == S_IDLE) && !rst;
    assign wr_valid     = (state_q == S_ISSUE);
    assign wr_kind      = kind_q;
    assign wr_voice     = voice_q;
    assign wr_note      = ev_note_q;
    assign wr_channel   = ev_channel_q;
    assign wr_velocity  = ev_velocity_q;
    assign active_count = active_count_q;
    assign steal_count  = steal_count_q;
    assign miss_count   = miss_count_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ev_on_d       = ev_on_q;
        ev_note_d     = ev_note_q;
        ev_channel_d  = ev_channel_q;
        ev_velocity_d = ev_velocity_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        rel_found_d   = rel_found_q;
        rel_idx_d     = rel_idx_q;
        rel_age_d     = rel_age_q;
        held_found_d  = held_found_q;
        held_idx_d    = held_idx_q;
        held_age_d    = held_age_q;
        kind_d        = kind_q;
        voice_d       = voice_q;
        used_d        = used_q;
        releasing_d   = releasing_q;
        note_d        = note_q;
        channel_d     = channel_q;
        stamp_d       = stamp_q;
        seq_d         = seq_q;
        steal_count_d = steal_count_q;
        miss_count_d  = miss_count_q;

        scan_age = seq_q - stamp_q[idx_q];
        scan_hit = used_q[idx_q] && (note_q[idx_q] == ev_note_q) &&
                   (channel_q[idx_q] == ev_channel_q) && (ev_on_q || !releasing_q[idx_q]);

        // Envelope-done clears come first so a same-cycle table write overrides them.
        if (rel_valid && releasing_q[rel_voice] &&
            !((state_q == S_ISSUE) && (rel_voice == voice_q))) begin
            used_d[rel_voice]      = 1'b0;
            releasing_d[rel_voice] = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (ev_valid && ev_ready) begin
                    ev_on_d       = ev_on;
                    ev_note_d     = ev_note;
                    ev_channel_d  = ev_channel;
                    ev_velocity_d = ev_velocity;
                    idx_d         = '0;
                    match_found_d = 1'b0;
                    free_found_d  = 1'b0;
                    rel_found_d   = 1'b0;
                    held_found_d  = 1'b0;
                    state_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_hit && !match_found_q) begin
                    match_found_d = 1'b1;
                    match_idx_d   = idx_q;
                end
                if (!used_q[idx_q] && !free_found_q) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                // Strict greater-than keeps the lower index on equal age.
                if (used_q[idx_q] && releasing_q[idx_q] &&
                    (!rel_found_q || (scan_age > rel_age_q))) begin
                    rel_found_d = 1'b1;
                    rel_idx_d   = idx_q;
                    rel_age_d   = scan_age;
                end
                if (used_q[idx_q] && !releasing_q[idx_q] &&
                    (!held_found_q || (scan_age > held_age_q))) begin
                    held_found_d = 1'b1;
                    held_idx_d   = idx_q;
                    held_age_d   = scan_age;
                end
                idx_d = idx_q + VOICE_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                if (ev_on_q) begin
                    state_d = S_ISSUE;
                    if (match_found_q) begin
                        kind_d  = K_START;
                        voice_d = match_idx_q;
                    end else if (free_found_q) begin
                        kind_d  = K_START;
                        voice_d = free_idx_q;
                    end else if (rel_found_q) begin
                        kind_d  = K_STEAL;
                        voice_d = rel_idx_q;
                    end else begin
                        kind_d  = K_STEAL;
                        voice_d = held_idx_q;
                    end
                end else if (match_found_q) begin
                    kind_d  = K_RELEASE;
                    voice_d = match_idx_q;
                    state_d = S_ISSUE;
                end else begin
                    if (miss_count_q != 8'hFF) begin
                        miss_count_d = miss_count_q + 8'd1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (wr_ready) begin
                    if (kind_q == K_RELEASE) begin
                        releasing_d[voice_q] = 1'b1;
                    end else begin
                        used_d[voice_q]      = 1'b1;
                        releasing_d[voice_q] = 1'b0;
                        note_d[voice_q]      = ev_note_q;
                        channel_d[voice_q]   = ev_channel_q;
                        stamp_d[voice_q]     = seq_q;
                        seq_d                = seq_q + 8'd1;
                        if ((kind_q == K_STEAL) && (steal_count_q != 8'hFF)) begin
                            steal_count_d = steal_count_q + 8'd1;
                        end
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        active_count_d = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            active_count_d = active_count_d + (VOICE_W + 1)'(used_q[i]);
        end
    end

    always_ff @(posedge clk32) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            ev_on_q        <= 1'b0;
            ev_note_q      <= '0;
            ev_channel_q   <= '0;
            ev_velocity_q  <= '0;
            match_found_q  <= 1'b0;
            match_idx_q    <= '0;
            free_found_q   <= 1'b0;
            free_idx_q     <= '0;
            rel_found_q    <= 1'b0;
            rel_idx_q      <= '0;
            rel_age_q      <= '0;
            held_found_q   <= 1'b0;
            held_idx_q     <= '0;
            held_age_q     <= '0;
            kind_q         <= K_START;
            voice_q        <= '0;
            used_q         <= '0;
            releasing_q    <= '0;
            note_q         <= '{default: '0};
            channel_q      <= '{default: '0};
            stamp_q        <= '{default: '0};
            seq_q          <= '0;
            active_count_q <= '0;
            steal_count_q  <= '0;
            miss_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            ev_on_q        <= ev_on_d;
            ev_note_q      <= ev_note_d;
            ev_channel_q   <= ev_channel_d;
            ev_velocity_q  <= ev_velocity_d;
            match_found_q  <= match_found_d;
            match_idx_q    <= match_idx_d;
            free_found_q   <= free_found_d;
            free_idx_q     <= free_idx_d;
            rel_found_q    <= rel_found_d;
            rel_idx_q      <= rel_idx_d;
            rel_age_q      <= rel_age_d;
            held_found_q   <= held_found_d;
            held_idx_q     <= held_idx_d;
            held_age_q     <= held_age_d;
            kind_q         <= kind_d;
            voice_q        <= voice_d;
            used_q         <= used_d;
            releasing_q    <= releasing_d;
            note_q         <= note_d;
            channel_q      <= channel_d;
            stamp_q        <= stamp_d;
            seq_q          <= seq_d;
            active_count_q <= active_count_d;
            steal_count_q  <= steal_count_d;
            miss_count_q   <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: one task per scenario, inline expected values.
module tb_voice_alloc;

    logic       clk32 = 1'b0;
    logic       rst = 1'b1;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic       ev_on = 1'b0;
    logic [6:0] ev_note = '0;
    logic [3:0] ev_channel = '0;
    logic [6:0] ev_velocity = '0;
    logic       rel_valid = 1'b0;
    logic [4:0] rel_voice = '0;
    logic       wr_valid;
    logic       wr_ready = 1'b1;
    logic [1:0] wr_kind;
    logic [4:0] wr_voice;
    logic [6:0] wr_note;
    logic [3:0] wr_channel;
    logic [6:0] wr_velocity;
    logic [5:0] active_count;
    logic [7:0] steal_count;
    logic [7:0] miss_count;

    int errors = 0;
    int checks = 0;

    voice_alloc #(.NUM_VOICES(32), .VOICE_W(5)) dut (
        .clk32(clk32), .rst(rst),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_note(ev_note),
        .ev_channel(ev_channel), .ev_velocity(ev_velocity),
        .rel_valid(rel_valid), .rel_voice(rel_voice),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_kind(wr_kind), .wr_voice(wr_voice),
        .wr_note(wr_note), .wr_channel(wr_channel), .wr_velocity(wr_velocity),
        .active_count(active_count), .steal_count(steal_count), .miss_count(miss_count)
    );

    always #5 clk32 = ~clk32;

    task automatic step();
        @(posedge clk32);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ev_valid = 1'b0;
        rel_valid = 1'b0;
        wr_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    // Sends one event with wr_ready high; returns the command seen (if any) and its latency.
    task automatic do_event(input logic on, input logic [6:0] note, input logic [3:0] ch,
                            input logic [6:0] vel, output logic got, output logic [1:0] kind,
                            output logic [4:0] voice, output logic [6:0] onote,
                            output logic [3:0] och, output logic [6:0] ovel, output int lat);
        int w;
        got = 1'b0; kind = '0; voice = '0; onote = '0; och = '0; ovel = '0; lat = 0;
        w = 0;
        while (ev_ready !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        wr_ready = 1'b1;
        ev_valid = 1'b1; ev_on = on; ev_note = note; ev_channel = ch; ev_velocity = vel;
        step();
        ev_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (wr_valid === 1'b1) begin
                got = 1'b1; lat = n; kind = wr_kind; voice = wr_voice;
                onote = wr_note; och = wr_channel; ovel = wr_velocity;
                break;
            end
        end
        if (got) step();
        step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ev_ready: got %b expected 1", ev_ready); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        checks++; if ({wr_kind, wr_voice, wr_note, wr_channel, wr_velocity} !== 25'd0) begin
            errors++; $display("FAIL reset_payload: got kind=%0d voice=%0d note=%0d ch=%0d vel=%0d expected all 0",
                               wr_kind, wr_voice, wr_note, wr_channel, wr_velocity); end
        checks++; if (active_count !== 6'd0) begin errors++; $display("FAIL reset_active: got %0d expected 0", active_count); end
        checks++; if (steal_count !== 8'd0) begin errors++; $display("FAIL reset_steal: got %0d expected 0", steal_count); end
        checks++; if (miss_count !== 8'd0) begin errors++; $display("FAIL reset_miss: got %0d expected 0", miss_count); end
    endtask

    task automatic test_first_note();
        logic got; logic [1:0] k; logic [4:0] v; logic [6:0] n; logic [3:0] c; logic [6:0] vl; int lat;
        do_reset();
        do_event(1'b1, 7'd60, 4'd0, 7'd100, got, k, v, n, c, vl, lat);
        checks++; if (got !== 1'b1 || lat != 33) begin errors++; $display("FAIL first_latency: got valid=%b lat=%0d expected valid=1 lat=33", got, lat); end
        checks++; if (k !== 2'd0 || v !== 5'd0) begin errors++; $display("FAIL first_cmd: got kind=%0d voice=%0d expected kind=0 voice=0", k, v); end
        checks++; if (n !== 7'd60 || c !== 4'd0 || vl !== 7'd100) begin errors++; $display("FAIL first_payload: got %0d/%0d/%0d expected 60/0/100", n, c, vl); end
        checks++; if (active_count !== 6'd1) begin errors++; $display("FAIL first_active: got %0d expected 1", active_count); end
    endtask

    task automatic test_retrigger();
        logic got; logic [1:0] k; logic [4:0] v; logic [6:0] n; logic [3:0] c; logic [6:0] vl; int lat;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            do_event(1'b1, 7'd60, 4'd0, 7'd90, got, k, v, n, c, vl, lat);
            checks++; if (got !== 1'b1 || k !== 2'd0 || v !== 5'd0) begin errors++;
                $display("FAIL retrigger_%0d: got valid=%b kind=%0d voice=%0d expected 1/0/0", i, got, k, v); end
        end
        checks++; if (active_count !== 6'd1) begin errors++; $display("FAIL retrigger_active: got %0d expected 1", active_count); end
    endtask

    task automatic test_steal_held();
        logic got; logic [1:0] k; logic [4:0] v; logic [6:0] n; logic [3:0] c; logic [6:0] vl; int lat;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            do_event(1'b1, 7'(20 + i), 4'd1, 7'd64, got, k, v, n, c, vl, lat);
            checks++; if (got !== 1'b1 || k !== 2'd0 || v !== 5'(i)) begin errors++;
                $display("FAIL fill_%0d: got valid=%b kind=%0d voice=%0d expected 1/0/%0d", i, got, k, v, i); end
        end
        checks++; if (active_count !== 6'd32) begin errors++; $display("FAIL fill_active: got %0d expected 32", active_count); end
        do_event(1'b1, 7'd100, 4'd1, 7'd64, got, k, v, n, c, vl, lat);
        checks++; if (got !== 1'b1 || k !== 2'd2 || v !== 5'd0) begin errors++;
            $display("FAIL steal_held: got valid=%b kind=%0d voice=%0d expected 1/2/0", got, k, v); end
        checks++; if (steal_count !== 8'd1) begin errors++; $display("FAIL steal_count: got %0d expected 1", steal_count); end
        checks++; if (active_count !== 6'd32) begin errors++; $display("FAIL steal_active: got %0d expected 32", active_count); end
    endtask

    task automatic test_steal_releasing();
        logic got; logic [1:0] k; logic [4:0] v; logic [6:0] n; logic [3:0] c; logic [6:0] vl; int lat;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            do_event(1'b1, 7'(i), 4'd0, 7'd10, got, k, v, n, c, vl, lat);
        end
        do_event(1'b0, 7'd7, 4'd0, 7'd0, got, k, v, n, c, vl, lat);
        checks++; if (got !== 1'b1 || k !== 2'd1 || v !== 5'd7) begin errors++;
            $display("FAIL release_7: got valid=%b kind=%0d voice=%0d expected 1/1/7", got, k, v); end
        do_event(1'b1, 7'd90, 4'd0, 7'd33, got, k, v, n, c, vl, lat);
        checks++; if (got !== 1'b1 || k !== 2'd2 || v !== 5'd7) begin errors++;
            $display("FAIL steal_rel: got valid=%b kind=%0d voice=%0d expected 1/2/7", got, k, v); end
        checks++; if (steal_count !== 8'd1) begin errors++; $display("FAIL steal_rel_count: got %0d expected 1", steal_count); end
    endtask

    task automatic test_miss_and_free();
        logic got; logic [1:0] k; logic [4:0] v; logic [6:0] n; logic [3:0] c; logic [6:0] vl; int lat;
        do_reset();
        do_event(1'b1, 7'd60, 4'd0, 7'd100, got, k, v, n, c, vl, lat);
        rel_valid = 1'b1; rel_voice = 5'd0;
        step();
        rel_valid = 1'b0;
        step(); step();
        checks++; if (active_count !== 6'd1) begin errors++; $display("FAIL rel_on_held: got %0d expected 1", active_count); end
        do_event(1'b0, 7'd72, 4'd3, 7'd0, got, k, v, n, c, vl, lat);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL miss_no_cmd: got valid=%b expected 0", got); end
        checks++; if (miss_count !== 8'd1) begin errors++; $display("FAIL miss_count: got %0d expected 1", miss_count); end
        do_event(1'b0, 7'd60, 4'd0, 7'd0, got, k, v, n, c, vl, lat);
        checks++; if (got !== 1'b1 || k !== 2'd1 || v !== 5'd0) begin errors++;
            $display("FAIL release_0: got valid=%b kind=%0d voice=%0d expected 1/1/0", got, k, v); end
        do_event(1'b0, 7'd60, 4'd0, 7'd0, got, k, v, n, c, vl, lat);
        checks++; if (got !== 1'b0 || miss_count !== 8'd2) begin errors++;
            $display("FAIL double_off: got valid=%b miss=%0d expected 0/2", got, miss_count); end
        checks++; if (active_count !== 6'd1) begin errors++; $display("FAIL releasing_active: got %0d expected 1", active_count); end
        rel_valid = 1'b1; rel_voice = 5'd0;
        step();
        rel_valid = 1'b0;
        step(); step();
        checks++; if (active_count !== 6'd0) begin errors++; $display("FAIL rel_free: got %0d expected 0", active_count); end
        do_event(1'b1, 7'd61, 4'd2, 7'd90, got, k, v, n, c, vl, lat);
        checks++; if (got !== 1'b1 || k !== 2'd0 || v !== 5'd0) begin errors++;
            $display("FAIL reuse_0: got valid=%b kind=%0d voice=%0d expected 1/0/0", got, k, v); end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1, na;
        logic rb;
        do_reset();
        acc0 = 0; acc1 = 0; na = 0;
        wr_ready = 1'b1;
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd10; ev_channel = 4'd1; ev_velocity = 7'd50;
        for (int n = 1; n <= 120 && na < 2; n++) begin
            rb = ev_ready;
            step();
            if (rb === 1'b1) begin
                if (na == 0) acc0 = n; else acc1 = n;
                na++;
                ev_note = 7'd11;
            end
        end
        ev_valid = 1'b0;
        checks++; if (na != 2 || (acc1 - acc0) != 35) begin errors++;
            $display("FAIL b2b_spacing: got accepts=%0d spacing=%0d expected 2/35", na, acc1 - acc0); end
        for (int i = 0; i < 40; i++) step();
        checks++; if (active_count !== 6'd2) begin errors++; $display("FAIL b2b_active: got %0d expected 2", active_count); end
    endtask

    task automatic test_stall_and_rst();
        logic got; logic [1:0] k; logic [4:0] v; logic [6:0] n; logic [3:0] c; logic [6:0] vl; int lat;
        logic seen;
        do_reset();
        do_event(1'b1, 7'd60, 4'd0, 7'd100, got, k, v, n, c, vl, lat);
        do_event(1'b0, 7'd60, 4'd0, 7'd0, got, k, v, n, c, vl, lat);
        wr_ready = 1'b0;
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_channel = 4'd0; ev_velocity = 7'd77;
        step();
        ev_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (wr_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (!seen || wr_kind !== 2'd0 || wr_voice !== 5'd0) begin errors++;
            $display("FAIL stall_cmd: got valid=%b kind=%0d voice=%0d expected 1/0/0", seen, wr_kind, wr_voice); end
        for (int i = 0; i < 10; i++) begin
            rel_valid = (i == 2); rel_voice = 5'd0;
            step();
            checks++; if (wr_valid !== 1'b1 || wr_kind !== 2'd0 || wr_voice !== 5'd0 ||
                          wr_note !== 7'd60 || wr_channel !== 4'd0 || wr_velocity !== 7'd77) begin errors++;
                $display("FAIL stall_hold_%0d: got v=%b k=%0d vo=%0d n=%0d c=%0d vel=%0d expected 1/0/0/60/0/77",
                         i, wr_valid, wr_kind, wr_voice, wr_note, wr_channel, wr_velocity); end
        end
        rel_valid = 1'b0;
        checks++; if (active_count !== 6'd1) begin errors++; $display("FAIL stall_rel_ignored: got %0d expected 1", active_count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_ready = 1'b1;
        #1;
        checks++; if (wr_valid !== 1'b0 || ev_ready !== 1'b1) begin errors++;
            $display("FAIL rst_abort: got wr_valid=%b ev_ready=%b expected 0/1", wr_valid, ev_ready); end
        checks++; if ({wr_kind, wr_voice, wr_note, wr_channel, wr_velocity} !== 25'd0) begin errors++;
            $display("FAIL rst_payload: got kind=%0d voice=%0d note=%0d ch=%0d vel=%0d expected all 0",
                     wr_kind, wr_voice, wr_note, wr_channel, wr_velocity); end
        checks++; if (active_count !== 6'd0 || miss_count !== 8'd0 || steal_count !== 8'd0) begin errors++;
            $display("FAIL rst_counts: got active=%0d miss=%0d steal=%0d expected 0/0/0", active_count, miss_count, steal_count); end
    endtask

    initial begin
        test_reset();
        test_first_note();
        test_retrigger();
        test_steal_held();
        test_steal_releasing();
        test_miss_and_free();
        test_back_to_back();
        test_stall_and_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
